ct_idu_rf_prf_vreg_rd_port: RTL and testbench
=============================================

Name: ct_idu_rf_prf_vreg_rd_port

Overview:
- One vector register-file read port. Indexes the flat vreg array outputs by a physical register number (preg).
- Bypasses same-cycle writeback data from vfpu pipe6, vfpu pipe7 and lsu pipe3.
- Delivers the 64-bit operand through a 1-cycle registered output with a 2-entry (main + skid) valid/ready buffer.
- Sits directly downstream of the per-entry gated vreg registers and feeds the vector issue/execute operand path.

Parameters:
- ENTRIES, 64, number of physical vregs.
- PREG_W, 6, preg index width (log2 ENTRIES).
- DATA_W, 64, vreg data width.

Ports:
- forever_cpuclk  in  1  free-running core clock.
- cpurst  in  1  async active-high reset.
- cp0_idu_icg_en  in  1  module clock-gate enable.
- cp0_yy_clk_en  in  1  global clock-gate enable.
- pad_yy_icg_scan_en  in  1  scan clock-gate override.
- rd_flush  in  1  synchronous flush of buffered reads.
- rd_req_vld  in  1  read request valid.
- rd_req_rdy  out  1  read request accepted when high.
- rd_req_preg  in  PREG_W  preg to read.
- prf_vreg_dout  in  ENTRIES*DATA_W  array contents; entry i at [i*DATA_W +: DATA_W].
- vfpu_idu_ex5_pipe6_wb_vreg_vld  in  1  pipe6 write valid.
- vfpu_idu_ex5_pipe6_wb_vreg_preg  in  PREG_W  pipe6 write preg.
- vfpu_idu_ex5_pipe6_wb_vreg_data  in  DATA_W  pipe6 write data.
- vfpu_idu_ex5_pipe7_wb_vreg_vld / _preg / _data  in  1/PREG_W/DATA_W  pipe7 write port, same meaning.
- lsu_idu_wb_pipe3_wb_vreg_vld / _preg / _data  in  1/PREG_W/DATA_W  pipe3 write port, same meaning.
- rd_data_vld  out  1  operand valid.
- rd_data_rdy  in  1  consumer ready.
- rd_data  out  DATA_W  operand.
- rd_data_preg  out  PREG_W  preg of the operand.
- err_wb_conflict  out  1  sticky: two or more valid wb ports targeted the same preg in one cycle.

Behaviour:
- Clock and reset: one clock, forever_cpuclk; reset cpurst is asynchronous, active-high.
- Reset: main_vld=0, skid_vld=0, all data/preg regs 0, err_wb_conflict=0. Outputs therefore reset to rd_data_vld=0, rd_data=0, rd_data_preg=0, rd_req_rdy=1.
- Request side:
  - rd_req_rdy = !skid_vld (registered state only, no combinational path from rd_data_rdy).
  - Accept = rd_req_vld & rd_req_rdy & !rd_flush.
- Read data selection at accept:
  - If any valid wb port preg equals rd_req_preg, take the wb data; priority pipe6 > pipe7 > pipe3.
  - Otherwise take prf_vreg_dout[rd_req_preg].
- Latency: accepted in cycle N -> rd_data_vld=1 in cycle N+1. Full throughput when rd_data_rdy=1 every cycle.
- Output drain: drain = rd_data_vld & rd_data_rdy.
- Buffer transitions, evaluated per cycle, priority top-down:
  - rd_flush: main_vld<=0, skid_vld<=0. Flush wins over accept and drain.
  - accept & (!main_vld | drain) & !skid_vld: request loads main.
  - accept & main_vld & !drain: request loads skid.
  - drain & skid_vld: skid moves to main, skid_vld<=0. rd_req_rdy=0 this cycle, so no accept is possible.
  - drain & !accept & !skid_vld: main_vld<=0.
- Snoop: each valid buffered entry (main, skid) compares its preg with the wb ports every cycle.
  - On a match, its data is replaced with the wb data next cycle, same priority order.
  - Snoop and skid->main move in the same cycle: the moved data is the snooped value.
- Conflict detect: any two valid wb ports with equal preg in a cycle set err_wb_conflict next cycle. It is cleared only by reset.
- Clock gating:
  - Data/preg regs are clocked through gated_clk_cell.
  - local_en = accept | (drain & skid_vld) | any snoop hit.
  - external_en=1'b0, global_en=cp0_yy_clk_en, module_en=cp0_idu_icg_en.
  - Valid bits and err_wb_conflict are clocked by forever_cpuclk.
- Unused prf_vreg_dout entries beyond ENTRIES: none; preg always < ENTRIES.

Decomposition:
- Shared package: PREG_W, DATA_W, ENTRIES constants and a wb-port bundle (vld, preg, data).
- Sub-module ct_idu_rf_prf_vreg_byp_sel: combinational 3-port match plus priority mux, outputs hit and data. Instantiated three times: request, main snoop, skid snoop.

Test Plan:
- Plain read: array entry 5 = 64'h1111, request preg 5, rd_data_rdy=1 -> next cycle rd_data_vld=1, rd_data=64'h1111, rd_data_preg=5.
- Bypass priority: request preg 9 while pipe6 and pipe3 both write preg 9 (data A, C) -> rd_data=A next cycle; err_wb_conflict=1 and stays 1.
- Backpressure: rd_data_rdy=0, three back-to-back requests (pregs 1, 2, 3) -> third request sees rd_req_rdy=0. After rdy=1, outputs appear in order 1, 2, then 3 accepted and delivered; no loss or duplication.
- Snoop: preg 4 held in main under stall, pipe7 writes preg 4 with 64'hBEEF -> rd_data=64'hBEEF next cycle, still valid.
- Flush: main and skid valid, rd_flush=1 with rd_req_vld=1 -> next cycle rd_data_vld=0, rd_req_rdy=1, request not accepted.
- Async reset mid-stall: assert cpurst between clock edges -> rd_data_vld, rd_data and err_wb_conflict go to 0 immediately; rd_req_rdy=1.

Source files
------------

// File: rtl/ct_idu_rf_prf_vreg_rd_port_pkg.sv
// rtl/ct_idu_rf_prf_vreg_rd_port_pkg.sv - shared constants and writeback-port bundle for the vreg read port
package ct_idu_rf_prf_vreg_rd_port_pkg;

    localparam int ENTRIES = 64;
    localparam int PREG_W  = 6;
    localparam int DATA_W  = 64;

    typedef struct packed {
        logic              vld;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
    } wb_port_t;

    function automatic logic wb_same_target(input wb_port_t a, input wb_port_t b);
        return a.vld & b.vld & (a.preg == b.preg);
    endfunction

endpackage

// File: rtl/ct_idu_rf_prf_vreg_byp_sel.sv
// rtl/ct_idu_rf_prf_vreg_byp_sel.sv - 3-port writeback match with pipe6 > pipe7 > pipe3 priority
module ct_idu_rf_prf_vreg_byp_sel
    import ct_idu_rf_prf_vreg_rd_port_pkg::*;
(
    input  logic              vld_i,
    input  logic [PREG_W-1:0] preg_i,
    input  wb_port_t          wb6_i,
    input  wb_port_t          wb7_i,
    input  wb_port_t          wb3_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic hit6;
    logic hit7;
    logic hit3;

    assign hit6 = vld_i & wb6_i.vld & (wb6_i.preg == preg_i);
    assign hit7 = vld_i & wb7_i.vld & (wb7_i.preg == preg_i);
    assign hit3 = vld_i & wb3_i.vld & (wb3_i.preg == preg_i);

    always_comb begin
        hit_o  = hit6 | hit7 | hit3;
        data_o = '0;
        if (hit6) begin
            data_o = wb6_i.data;
        end else if (hit7) begin
            data_o = wb7_i.data;
        end else if (hit3) begin
            data_o = wb3_i.data;
        end
    end

endmodule

// File: rtl/gated_clk_cell.sv
// rtl/gated_clk_cell.sv - latch-based clock gate with scan override
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en;
    logic en_lat;

    assign clk_en = (global_en & module_en & (local_en | external_en)) | pad_yy_icg_scan_en;

    // Enable is captured while the clock is low so clk_out never glitches.
    always_latch begin
        if (!clk_in) begin
            en_lat <= clk_en;
        end
    end

    assign clk_out = clk_in & en_lat;

endmodule

// File: rtl/ct_idu_rf_prf_vreg_rd_port.sv
// rtl/ct_idu_rf_prf_vreg_rd_port.sv - vreg read port with wb bypass, snoop and main/skid output buffer
module ct_idu_rf_prf_vreg_rd_port
    import ct_idu_rf_prf_vreg_rd_port_pkg::*;
(
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      cp0_idu_icg_en,
    input  logic                      cp0_yy_clk_en,
    input  logic                      pad_yy_icg_scan_en,
    input  logic                      rd_flush,
    input  logic                      rd_req_vld,
    output logic                      rd_req_rdy,
    input  logic [PREG_W-1:0]         rd_req_preg,
    input  logic [ENTRIES*DATA_W-1:0] prf_vreg_dout,
    input  logic                      vfpu_idu_ex5_pipe6_wb_vreg_vld,
    input  logic [PREG_W-1:0]         vfpu_idu_ex5_pipe6_wb_vreg_preg,
    input  logic [DATA_W-1:0]         vfpu_idu_ex5_pipe6_wb_vreg_data,
    input  logic                      vfpu_idu_ex5_pipe7_wb_vreg_vld,
    input  logic [PREG_W-1:0]         vfpu_idu_ex5_pipe7_wb_vreg_preg,
    input  logic [DATA_W-1:0]         vfpu_idu_ex5_pipe7_wb_vreg_data,
    input  logic                      lsu_idu_wb_pipe3_wb_vreg_vld,
    input  logic [PREG_W-1:0]         lsu_idu_wb_pipe3_wb_vreg_preg,
    input  logic [DATA_W-1:0]         lsu_idu_wb_pipe3_wb_vreg_data,
    output logic                      rd_data_vld,
    input  logic                      rd_data_rdy,
    output logic [DATA_W-1:0]         rd_data,
    output logic [PREG_W-1:0]         rd_data_preg,
    output logic                      err_wb_conflict
);

    wb_port_t wb6;
    wb_port_t wb7;
    wb_port_t wb3;

    assign wb6 = '{vld: vfpu_idu_ex5_pipe6_wb_vreg_vld, preg: vfpu_idu_ex5_pipe6_wb_vreg_preg,
                   data: vfpu_idu_ex5_pipe6_wb_vreg_data};
    assign wb7 = '{vld: vfpu_idu_ex5_pipe7_wb_vreg_vld, preg: vfpu_idu_ex5_pipe7_wb_vreg_preg,
                   data: vfpu_idu_ex5_pipe7_wb_vreg_data};
    assign wb3 = '{vld: lsu_idu_wb_pipe3_wb_vreg_vld, preg: lsu_idu_wb_pipe3_wb_vreg_preg,
                   data: lsu_idu_wb_pipe3_wb_vreg_data};

    logic              main_vld_q, main_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PREG_W-1:0] main_preg_q, main_preg_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [PREG_W-1:0] skid_preg_q, skid_preg_d;
    logic              err_q, err_d;

    logic              accept;
    logic              drain;
    logic              load_main;
    logic              load_skid;
    logic              skid_to_main;
    logic              req_hit,  main_hit,  skid_hit;
    logic [DATA_W-1:0] req_byp,  main_byp,  skid_byp;
    logic [DATA_W-1:0] req_data, main_cur,  skid_cur;
    logic              local_en;
    logic              data_clk;

    assign rd_req_rdy   = !skid_vld_q;
    assign accept       = rd_req_vld & rd_req_rdy & !rd_flush;
    assign drain        = main_vld_q & rd_data_rdy;
    assign load_main    = accept & (!main_vld_q | drain);
    assign load_skid    = accept & main_vld_q & !drain;
    assign skid_to_main = drain & skid_vld_q;

    ct_idu_rf_prf_vreg_byp_sel u_req_sel (
        .vld_i  (1'b1),
        .preg_i (rd_req_preg),
        .wb6_i  (wb6),
        .wb7_i  (wb7),
        .wb3_i  (wb3),
        .hit_o  (req_hit),
        .data_o (req_byp)
    );

    ct_idu_rf_prf_vreg_byp_sel u_main_sel (
        .vld_i  (main_vld_q),
        .preg_i (main_preg_q),
        .wb6_i  (wb6),
        .wb7_i  (wb7),
        .wb3_i  (wb3),
        .hit_o  (main_hit),
        .data_o (main_byp)
    );

    ct_idu_rf_prf_vreg_byp_sel u_skid_sel (
        .vld_i  (skid_vld_q),
        .preg_i (skid_preg_q),
        .wb6_i  (wb6),
        .wb7_i  (wb7),
        .wb3_i  (wb3),
        .hit_o  (skid_hit),
        .data_o (skid_byp)
    );

    assign req_data = req_hit  ? req_byp  : prf_vreg_dout[int'(rd_req_preg)*DATA_W +: DATA_W];
    assign main_cur = main_hit ? main_byp : main_data_q;
    assign skid_cur = skid_hit ? skid_byp : skid_data_q;

    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (rd_flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (load_main) begin
            main_vld_d = 1'b1;
        end else if (load_skid) begin
            skid_vld_d = 1'b1;
        end else if (skid_to_main) begin
            skid_vld_d = 1'b0;
        end else if (drain) begin
            main_vld_d = 1'b0;
        end
    end

    // Data paths ignore flush; the cleared valid bits make stale contents harmless.
    always_comb begin
        main_data_d = main_cur;
        main_preg_d = main_preg_q;
        skid_data_d = skid_cur;
        skid_preg_d = skid_preg_q;
        if (load_main) begin
            main_data_d = req_data;
            main_preg_d = rd_req_preg;
        end else if (skid_to_main) begin
            main_data_d = skid_cur;
            main_preg_d = skid_preg_q;
        end
        if (load_skid) begin
            skid_data_d = req_data;
            skid_preg_d = rd_req_preg;
        end
    end

    assign err_d = err_q | wb_same_target(wb6, wb7) | wb_same_target(wb6, wb3)
                         | wb_same_target(wb7, wb3);

    assign local_en = accept | skid_to_main | main_hit | skid_hit;

    gated_clk_cell u_data_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_idu_icg_en),
        .local_en           (local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (data_clk)
    );

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge data_clk or posedge cpurst) begin
        if (cpurst) begin
            main_data_q <= '0;
            main_preg_q <= '0;
            skid_data_q <= '0;
            skid_preg_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            main_preg_q <= main_preg_d;
            skid_data_q <= skid_data_d;
            skid_preg_q <= skid_preg_d;
        end
    end

    assign rd_data_vld     = main_vld_q;
    assign rd_data         = main_data_q;
    assign rd_data_preg    = main_preg_q;
    assign err_wb_conflict = err_q;

endmodule

// File: tb/tb_ct_idu_rf_prf_vreg_rd_port.sv
// tb/tb_ct_idu_rf_prf_vreg_rd_port.sv - self-checking bench for the vreg read port
module tb_ct_idu_rf_prf_vreg_rd_port;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic [5:0]    req_preg = '0;
    logic [4095:0] prf;
    logic          w6_vld = 1'b0, w7_vld = 1'b0, w3_vld = 1'b0;
    logic [5:0]    w6_preg = '0, w7_preg = '0, w3_preg = '0;
    logic [63:0]   w6_data = '0, w7_data = '0, w3_data = '0;
    logic          dat_vld;
    logic          dat_rdy = 1'b1;
    logic [63:0]   dat;
    logic [5:0]    dat_preg;
    logic          err;

    logic [63:0]   arr [64];
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 64; i++) prf[i*64 +: 64] = arr[i];
    end

    ct_idu_rf_prf_vreg_rd_port dut (
        .forever_cpuclk                  (clk),
        .cpurst                          (rst),
        .cp0_idu_icg_en                  (1'b1),
        .cp0_yy_clk_en                   (1'b1),
        .pad_yy_icg_scan_en              (1'b0),
        .rd_flush                        (flush),
        .rd_req_vld                      (req_vld),
        .rd_req_rdy                      (req_rdy),
        .rd_req_preg                     (req_preg),
        .prf_vreg_dout                   (prf),
        .vfpu_idu_ex5_pipe6_wb_vreg_vld  (w6_vld),
        .vfpu_idu_ex5_pipe6_wb_vreg_preg (w6_preg),
        .vfpu_idu_ex5_pipe6_wb_vreg_data (w6_data),
        .vfpu_idu_ex5_pipe7_wb_vreg_vld  (w7_vld),
        .vfpu_idu_ex5_pipe7_wb_vreg_preg (w7_preg),
        .vfpu_idu_ex5_pipe7_wb_vreg_data (w7_data),
        .lsu_idu_wb_pipe3_wb_vreg_vld    (w3_vld),
        .lsu_idu_wb_pipe3_wb_vreg_preg   (w3_preg),
        .lsu_idu_wb_pipe3_wb_vreg_data   (w3_data),
        .rd_data_vld                     (dat_vld),
        .rd_data_rdy                     (dat_rdy),
        .rd_data                         (dat),
        .rd_data_preg                    (dat_preg),
        .err_wb_conflict                 (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: an in-order queue of at most two operands.
    typedef struct {
        logic [5:0]  preg;
        logic [63:0] data;
    } ent_t;
    ent_t mq[$];
    logic m_err = 1'b0;

    function automatic logic [64:0] wb_lookup(input logic [5:0] p);
        if (w6_vld && w6_preg == p) return {1'b1, w6_data};
        if (w7_vld && w7_preg == p) return {1'b1, w7_data};
        if (w3_vld && w3_preg == p) return {1'b1, w3_data};
        return {1'b0, 64'h0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            logic        acc;
            logic [64:0] b;
            acc = req_vld && (mq.size() < 2) && !flush;
            if ((w6_vld && w7_vld && w6_preg == w7_preg) || (w6_vld && w3_vld && w6_preg == w3_preg) ||
                (w7_vld && w3_vld && w7_preg == w3_preg))
                m_err = 1'b1;
            if (flush) begin
                mq.delete();
            end else begin
                for (int k = 0; k < mq.size(); k++) begin
                    b = wb_lookup(mq[k].preg);
                    if (b[64]) mq[k].data = b[63:0];
                end
                if (mq.size() > 0 && dat_rdy) void'(mq.pop_front());
                if (acc) begin
                    b = wb_lookup(req_preg);
                    mq.push_back('{req_preg, b[64] ? b[63:0] : arr[req_preg]});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_vld", 64'(dat_vld), 64'(mq.size() > 0));
            check("cmp_rdy", 64'(req_rdy), 64'(mq.size() < 2));
            check("cmp_err", 64'(err), 64'(m_err));
            if (mq.size() > 0) begin
                check("cmp_data", dat, mq[0].data);
                check("cmp_preg", 64'(dat_preg), 64'(mq[0].preg));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        w6_vld = 1'b0;
        w7_vld = 1'b0;
        w3_vld = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) arr[i] = {32'h5A00_0000 + 32'(i), 32'(i * 3 + 1)};
        arr[5] = 64'h1111;
        tick();
        tick();
        rst = 1'b0;
        check("reset_vld", 64'(dat_vld), 64'h0);
        check("reset_data", dat, 64'h0);
        check("reset_preg", 64'(dat_preg), 64'h0);
        check("reset_rdy", 64'(req_rdy), 64'h1);
        check("reset_err", 64'(err), 64'h0);

        // plain read
        req_vld = 1'b1; req_preg = 6'd5;
        tick();
        req_vld = 1'b0;
        check("plain_vld", 64'(dat_vld), 64'h1);
        check("plain_data", dat, 64'h1111);
        check("plain_preg", 64'(dat_preg), 64'd5);

        // bypass priority with pipe6/pipe3 conflict
        req_vld = 1'b1; req_preg = 6'd9;
        w6_vld = 1'b1; w6_preg = 6'd9; w6_data = 64'hAAAA_0000_0000_000A;
        w3_vld = 1'b1; w3_preg = 6'd9; w3_data = 64'hCCCC_0000_0000_000C;
        tick();
        req_vld = 1'b0; clear_wb();
        check("byp_data", dat, 64'hAAAA_0000_0000_000A);
        check("byp_err", 64'(err), 64'h1);
        tick();
        check("err_sticky", 64'(err), 64'h1);

        // backpressure
        dat_rdy = 1'b0;
        req_vld = 1'b1; req_preg = 6'd1;
        tick();
        check("bp_rdy_after1", 64'(req_rdy), 64'h1);
        req_preg = 6'd2;
        tick();
        check("bp_rdy_after2", 64'(req_rdy), 64'h0);
        req_preg = 6'd3;
        tick();
        check("bp_hold_preg", 64'(dat_preg), 64'd1);
        check("bp_hold_data", dat, arr[1]);
        dat_rdy = 1'b1;
        tick();
        check("bp_second_preg", 64'(dat_preg), 64'd2);
        check("bp_second_data", dat, arr[2]);
        check("bp_rdy_again", 64'(req_rdy), 64'h1);
        tick();
        req_vld = 1'b0;
        check("bp_third_preg", 64'(dat_preg), 64'd3);
        check("bp_third_data", dat, arr[3]);
        tick();
        check("bp_empty", 64'(dat_vld), 64'h0);

        // snoop under stall
        dat_rdy = 1'b0;
        req_vld = 1'b1; req_preg = 6'd4;
        tick();
        req_vld = 1'b0;
        check("snoop_before", dat, arr[4]);
        w7_vld = 1'b1; w7_preg = 6'd4; w7_data = 64'hBEEF;
        tick();
        clear_wb();
        check("snoop_data", dat, 64'hBEEF);
        check("snoop_vld", 64'(dat_vld), 64'h1);

        // flush with main and skid valid
        req_vld = 1'b1; req_preg = 6'd6;
        tick();
        check("flush_pre_rdy", 64'(req_rdy), 64'h0);
        flush = 1'b1; req_preg = 6'd7;
        tick();
        flush = 1'b0; req_vld = 1'b0;
        check("flush_vld", 64'(dat_vld), 64'h0);
        check("flush_rdy", 64'(req_rdy), 64'h1);
        tick();
        check("flush_no_accept", 64'(dat_vld), 64'h0);

        // mixed traffic against the model
        for (int i = 0; i < 48; i++) begin
            req_vld = (i % 4 != 3);
            req_preg = 6'((i * 7) % 64);
            dat_rdy = (i % 3 != 1);
            flush = (i == 30);
            w6_vld = (i % 5 == 0); w6_preg = 6'((i * 7 + 57) % 64); w6_data = {32'hC0DE_0006, 32'(i)};
            w7_vld = (i % 7 == 2); w7_preg = 6'((i * 7 + 50) % 64); w7_data = {32'hC0DE_0007, 32'(i)};
            w3_vld = (i % 6 == 4); w3_preg = 6'((i * 7) % 64);      w3_data = {32'hC0DE_0003, 32'(i)};
            tick();
        end
        req_vld = 1'b0; flush = 1'b0; clear_wb(); dat_rdy = 1'b1;
        tick();
        tick();
        tick();

        // async reset mid-stall
        dat_rdy = 1'b0;
        req_vld = 1'b1; req_preg = 6'd8;
        tick();
        req_preg = 6'd10;
        w6_vld = 1'b1; w6_preg = 6'd20; w6_data = 64'h1;
        w7_vld = 1'b1; w7_preg = 6'd20; w7_data = 64'h2;
        tick();
        req_vld = 1'b0; clear_wb();
        check("stall_vld", 64'(dat_vld), 64'h1);
        check("stall_err", 64'(err), 64'h1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_vld", 64'(dat_vld), 64'h0);
        check("arst_data", dat, 64'h0);
        check("arst_err", 64'(err), 64'h0);
        check("arst_rdy", 64'(req_rdy), 64'h1);
        tick();
        tick();
        rst = 1'b0;
        dat_rdy = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
